// File: rtl/alu_word_sequencer_if.sv
// Request/result and ALU-slice bundle for alu_word_sequencer.
// ALU_SEQ_ABORT_EN adds the abort request line.
interface alu_word_sequencer_if #(
    parameter int unsigned WORDS = 4
);
    logic                   start;
    logic [1:0]             op;
    logic                   cin;
    logic [16*WORDS-1:0]    a_in;
    logic [16*WORDS-1:0]    b_in;
    logic                   busy;
    logic                   done;
    logic [16*WORDS-1:0]    result;
    logic                   cout;
    logic                   ovf;
    logic                   zero;
`ifdef ALU_SEQ_ABORT_EN
    logic                   abort;
`endif
    logic [15:0]            alu_a;
    logic [15:0]            alu_b;
    logic [1:0]             alu_s;
    logic                   alu_ci;
    logic [15:0]            alu_r;
    logic                   alu_co;
    logic                   alu_v;
    logic                   alu_z;

`ifdef ALU_SEQ_ABORT_EN
    modport master (
        output start, op, cin, a_in, b_in, abort,
        input  busy, done, result, cout, ovf, zero
    );
    modport slave (
        input  start, op, cin, a_in, b_in, abort,
        output busy, done, result, cout, ovf, zero,
        output alu_a, alu_b, alu_s, alu_ci,
        input  alu_r, alu_co, alu_v, alu_z
    );
`else
    modport master (
        output start, op, cin, a_in, b_in,
        input  busy, done, result, cout, ovf, zero
    );
    modport slave (
        input  start, op, cin, a_in, b_in,
        output busy, done, result, cout, ovf, zero,
        output alu_a, alu_b, alu_s, alu_ci,
        input  alu_r, alu_co, alu_v, alu_z
    );
`endif

    modport alu (
        input  alu_a, alu_b, alu_s, alu_ci,
        output alu_r, alu_co, alu_v, alu_z
    );
endinterface

// File: rtl/alu_word_sequencer.sv
// Drives a 16-bit combinational ALU one slice per cycle, LS slice first, to build a WORDS-wide result.
// Optional feature: ALU_SEQ_ABORT_EN (abort input cancels a RUN without a done pulse).
module alu_word_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_word_sequencer_if.slave bus
);
    localparam int unsigned IDXW = $clog2(WORDS + 1);
    localparam int unsigned SELW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDXW-1:0]        r_idx;
    logic [IDXW-1:0]        w_idx_nxt;
    logic [1:0]             r_op;
    logic                   r_cin;
    logic                   r_carry;
    logic                   r_zacc;
    logic [WORDS-1:0][15:0] r_a;
    logic [WORDS-1:0][15:0] r_b;
    logic [WORDS-1:0][15:0] r_acc;
    logic [WORDS-1:0][15:0] r_result;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   r_zero;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_abort;
    logic [SELW-1:0]        w_sel;
    logic [WORDS-1:0][15:0] w_acc_upd;
    logic [15:0]            w_alu_a;
    logic [15:0]            w_alu_b;
    logic [1:0]             w_alu_s;
    logic                   w_alu_ci;

`ifdef ALU_SEQ_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_sel    = r_idx[SELW-1:0];
    assign w_last   = (r_idx == IDXW'(WORDS - 1));
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_alu_a     = '0;
        w_alu_b     = '0;
        w_alu_s     = '0;
        w_alu_ci    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = '0;
                end
            end
            RUN: begin
                w_alu_a = r_a[w_sel];
                w_alu_b = r_b[w_sel];
                w_alu_s = r_op;
                // Carry chains only for ADD; slice 0 takes the latched cin.
                if (r_op == 2'b00) begin
                    w_alu_ci = (r_idx == '0) ? r_cin : r_carry;
                end
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + IDXW'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_acc_upd        = r_acc;
        w_acc_upd[w_sel] = bus.alu_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_cin    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_op   <= bus.op;
            r_cin  <= bus.cin;
            r_a    <= bus.a_in;
            r_b    <= bus.b_in;
            r_zacc <= 1'b1;
        end else if ((r_state == RUN) && !w_abort) begin
            r_acc   <= w_acc_upd;
            r_carry <= bus.alu_co;
            r_zacc  <= r_zacc & bus.alu_z;
            // Final slice results are taken straight from the ALU on the same edge.
            if (w_last) begin
                r_result <= w_acc_upd;
                r_cout   <= (r_op == 2'b00) ? bus.alu_co : 1'b0;
                r_ovf    <= (r_op == 2'b00) ? bus.alu_v : 1'b0;
                r_zero   <= r_zacc & bus.alu_z;
            end
        end
    end

    assign bus.busy   = (r_state == RUN);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;
    assign bus.zero   = r_zero;
    assign bus.alu_a  = w_alu_a;
    assign bus.alu_b  = w_alu_b;
    assign bus.alu_s  = w_alu_s;
    assign bus.alu_ci = w_alu_ci;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Randomised and directed bench for alu_word_sequencer with a wide-arithmetic reference model.
module tb_alu_word_sequencer;
    localparam int W  = 4;
    localparam int NB = 16 * W;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_word_sequencer_if #(.WORDS(W)) bus ();

    alu_word_sequencer #(.WORDS(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit ALU beside the sequencer
    always_comb begin
        logic [16:0] s;
        s = 17'd0;
        bus.alu_co = 1'b0;
        bus.alu_v  = 1'b0;
        case (bus.alu_s)
            2'b00: begin
                s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, bus.alu_ci};
                bus.alu_r  = s[15:0];
                bus.alu_co = s[16];
                bus.alu_v  = (bus.alu_a[15] == bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
            end
            2'b01:   bus.alu_r = bus.alu_a ^ bus.alu_b;
            2'b10:   bus.alu_r = bus.alu_a & bus.alu_b;
            default: bus.alu_r = bus.alu_a;
        endcase
        bus.alu_z = (bus.alu_r == 16'd0);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_age;   // cycles since accepted start; -1 when no job
    logic [NB-1:0] m_a, m_b;
    logic [1:0]    m_op;
    logic          m_cin;
    logic [NB-1:0] e_res;
    logic          e_cout, e_ovf, e_zero;

    function automatic logic carry_in(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                      input logic ci, input int k);
        logic [NB:0] m;
        logic [NB:0] s;
        m = ({{NB{1'b0}}, 1'b1} << (16 * k)) - 1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{NB{1'b0}}, ci};
        return s[16 * k];
    endfunction

    task automatic model_finish();
        logic [NB:0] sum;
        e_cout = 1'b0;
        e_ovf  = 1'b0;
        case (m_op)
            2'b00: begin
                sum    = {1'b0, m_a} + {1'b0, m_b} + {{NB{1'b0}}, m_cin};
                e_res  = sum[NB-1:0];
                e_cout = sum[NB];
                e_ovf  = (m_a[NB-1] == m_b[NB-1]) && (e_res[NB-1] != m_a[NB-1]);
            end
            2'b01:   e_res = m_a ^ m_b;
            2'b10:   e_res = m_a & m_b;
            default: e_res = m_a;
        endcase
        e_zero = (e_res == '0);
    endtask

    initial begin
        m_age = -1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_age  = -1;
                e_res  = '0;
                e_cout = 1'b0;
                e_ovf  = 1'b0;
                e_zero = 1'b0;
            end else begin
                int  old;
                logic ab;
                old = m_age;
                ab  = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
                ab = bus.abort;
`endif
                if (old >= 0 && old < W) begin
                    if (ab) m_age = -1;
                    else begin
                        m_age = old + 1;
                        if (m_age == W) model_finish();
                    end
                end else begin
                    m_age = -1;
                end
                if ((old < 0 || old == W) && bus.start) begin
                    m_a   = bus.a_in;
                    m_b   = bus.b_in;
                    m_op  = bus.op;
                    m_cin = bus.cin;
                    m_age = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic        x_busy;
                logic [15:0] x_a, x_b;
                logic [1:0]  x_s;
                logic        x_ci;
                x_busy = (m_age >= 0) && (m_age < W);
                x_a = 16'd0; x_b = 16'd0; x_s = 2'd0; x_ci = 1'b0;
                if (x_busy) begin
                    x_a = m_a[16*m_age +: 16];
                    x_b = m_b[16*m_age +: 16];
                    x_s = m_op;
                    if (m_op == 2'b00) x_ci = carry_in(m_a, m_b, m_cin, m_age);
                end
                chk("busy",   128'(bus.busy),   128'(x_busy));
                chk("done",   128'(bus.done),   128'(m_age == W));
                chk("alu_a",  128'(bus.alu_a),  128'(x_a));
                chk("alu_b",  128'(bus.alu_b),  128'(x_b));
                chk("alu_s",  128'(bus.alu_s),  128'(x_s));
                chk("alu_ci", 128'(bus.alu_ci), 128'(x_ci));
                chk("result", 128'(bus.result), 128'(e_res));
                chk("cout",   128'(bus.cout),   128'(e_cout));
                chk("ovf",    128'(bus.ovf),    128'(e_ovf));
                chk("zero",   128'(bus.zero),   128'(e_zero));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic ci_log [W];

    task automatic do_start(input logic [NB-1:0] a, input logic [NB-1:0] b,
                            input logic [1:0] op, input logic ci);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.op    = op;
        bus.cin   = ci;
        bus.start = 1'b1;
    endtask

    // Called at negedge+1 with start raised; returns negedges until done (20 = timed out).
    task automatic wait_done(input int poke_at, output int n);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (n <= W) ci_log[n-1] = bus.alu_ci;
            if (bus.done === 1'b1) break;
            #1;
            if (n == 1 || n == poke_at + 1) bus.start = 1'b0;
            if (n == poke_at) begin
                bus.start = 1'b1;
                bus.a_in  = ~bus.a_in;
            end
        end
        bus.start = 1'b0;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [NB-1:0] pick_wide();
        logic [NB-1:0] v;
        for (int s = 0; s < W; s++) v[16*s +: 16] = pick16();
        return v;
    endfunction

    initial begin
        int n;
        int extra;
        logic [NB-1:0] t1a, t1b, t3a, t3b, all1, pat;
        n_checks = 0;
        n_errors = 0;
        t1a  = 64'h0000_0000_0000_FFFF;
        t1b  = 64'h0000_0000_0000_0001;
        t3a  = 64'h7FFF_FFFF_FFFF_FFFF;
        t3b  = 64'h0000_0000_0000_0001;
        all1 = '1;
        pat  = 64'h1234_5678_9ABC_DEF0;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.cin   = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
`ifdef ALU_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        #3;
        chk("rst_busy",   128'(bus.busy),   128'(0));
        chk("rst_result", 128'(bus.result), 128'(0));
        chk("rst_alu_a",  128'(bus.alu_a),  128'(0));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;

        // ADD with a carry crossing into slice 1
        do_start(t1a, t1b, 2'b00, 1'b0);
        wait_done(0, n);
        chk("t1_latency", 128'(n), 128'(5));
        chk("t1_result",  128'(bus.result), 128'(64'h0000_0000_0001_0000));
        chk("t1_flags",   128'({bus.cout, bus.ovf, bus.zero}), 128'(3'b000));
        @(negedge clk); #1;

        // all-ones plus cin ripples through every slice
        do_start(all1, '0, 2'b00, 1'b1);
        wait_done(0, n);
        chk("t2_result", 128'(bus.result), 128'(0));
        chk("t2_flags",  128'({bus.cout, bus.ovf, bus.zero}), 128'(3'b101));
        chk("t2_ci_123", 128'({ci_log[1], ci_log[2], ci_log[3]}), 128'(3'b111));
        @(negedge clk); #1;

        // signed overflow
        do_start(t3a, t3b, 2'b00, 1'b0);
        wait_done(0, n);
        chk("t3_result", 128'(bus.result), 128'(64'h8000_0000_0000_0000));
        chk("t3_ovf_cout", 128'({bus.ovf, bus.cout}), 128'(2'b10));
        @(negedge clk); #1;

        // XOR ignores cin; a start during RUN is dropped
        do_start(pat, pat, 2'b01, 1'b1);
        wait_done(2, n);
        chk("t4_latency", 128'(n), 128'(5));
        chk("t4_ci_all",  128'({ci_log[0], ci_log[1], ci_log[2], ci_log[3]}), 128'(0));
        chk("t4_result",  128'(bus.result), 128'(0));
        chk("t4_flags",   128'({bus.cout, bus.zero}), 128'(2'b01));
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        chk("t4_single_done", 128'(extra), 128'(0));
        #1;

        // back-to-back issue from the DONE cycle
        do_start(t1a, t1b, 2'b00, 1'b0);
        wait_done(0, n);
        #1 do_start(t3a, t3b, 2'b00, 1'b0);
        wait_done(0, n);
        chk("b2b_latency", 128'(n), 128'(5));
        chk("b2b_result",  128'(bus.result), 128'(64'h8000_0000_0000_0000));
        @(negedge clk); #1;

`ifdef ALU_SEQ_ABORT_EN
        // abort at RUN cycle 1 keeps the previous result
        do_start(t1a, t1b, 2'b00, 1'b0);
        wait_done(0, n);
        #1 do_start(t3a, t3b, 2'b00, 1'b0);
        @(negedge clk); #1 bus.start = 1'b0;
        @(negedge clk); #1 bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_busy",   128'(bus.busy),   128'(0));
        chk("abort_result", 128'(bus.result), 128'(64'h0000_0000_0001_0000));
        #1 bus.abort = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        chk("abort_no_done", 128'(extra), 128'(0));
        #1;
`endif

        // reset during RUN cycle 2
        do_start(all1, '0, 2'b00, 1'b1);
        @(negedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   128'({bus.busy, bus.done}), 128'(0));
        chk("mid_rst_result", 128'(bus.result), 128'(0));
        chk("mid_rst_flags",  128'({bus.cout, bus.ovf, bus.zero}), 128'(0));
        chk("mid_rst_alu",    128'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_ci}), 128'(0));
        @(negedge clk); #1 rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        chk("mid_rst_no_done", 128'(extra), 128'(0));
        #1;

        // random traffic, including starts while busy and from DONE
        for (int c = 0; c < 1500; c++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.cin   = 1'($urandom_range(0, 1));
            bus.a_in  = pick_wide();
            bus.b_in  = pick_wide();
`ifdef ALU_SEQ_ABORT_EN
            bus.abort = ($urandom_range(0, 15) == 0);
`endif
            @(negedge clk);
            #1;
        end
        bus.start = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (10) @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-precision controller for the 16-bit cascadable ALU (A, B, S, Ci → R, Co, V, Z). It accepts WORDS×16-bit operands and an opcode, then drives the ALU one 16-bit slice per cycle, least-significant slice first, chaining carry between slices. It assembles the wide result and flags and signals completion with a one-cycle pulse. The ALU itself stays combinational and is instantiated beside this block.

## Interface
- WORDS, 4: number of 16-bit slices; legal range 1..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  2  ALU select: 00 ADD, 01 XOR, 10 AND, 11 transparency.
- cin  in  1  carry-in for slice 0; ADD only.
- a_in, b_in  in  16*WORDS  operands; sampled only on an accepted start.
- alu_a, alu_b  out  16  current slice to the ALU.
- alu_s  out  2  ALU select.
- alu_ci  out  1  ALU carry-in.
- alu_r  in  16  ALU result.
- alu_co, alu_v, alu_z  in  1  ALU carry-out, overflow and zero flags.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle completion pulse.
- result  out  16*WORDS  assembled result.
- cout, ovf, zero  out  1  final flags.
- abort  in  1  present only with ALU_SEQ_ABORT_EN defined.

## Operation
- States: IDLE, RUN, DONE. Slice index idx is ceil(log2(WORDS+1)) bits wide.
- IDLE or DONE with start=1:
  - Latch op, cin, a_in and b_in.
  - Set idx=0, clear the zero accumulator (set to 1), go to RUN.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, combinational drive:
  - alu_a and alu_b are slice idx of the latched operands; alu_s is the latched op.
  - alu_ci is latched cin for idx=0 and the carry register for idx>0, when op=00. It is 0 for any other op.
- RUN, each clock edge:
  - Capture alu_r into accumulator slice idx.
  - Capture alu_co into the carry register.
  - AND alu_z into the zero accumulator.
  - Capture alu_v.
- RUN with idx=WORDS-1:
  - Load result, cout, ovf and zero from the accumulators; go to DONE.
  - cout = alu_co when op=00, else 0.
  - ovf = alu_v of the top slice when op=00, else 0.
  - zero = AND of all slice alu_z values.
- RUN with idx<WORDS-1: increment idx.
- Outside RUN, alu_a, alu_b, alu_s and alu_ci are 0.
- start while busy=1 is ignored. It is not queued, and a_in/b_in changes have no effect.
- result, cout, ovf and zero hold their values until the next completion; they are not cleared on start.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, idx=0, busy=0, done=0, result=0, cout=0, ovf=0, zero=0. alu_a, alu_b, alu_s and alu_ci are 0.
- Start is sampled at edge t. RUN covers cycles t..t+WORDS-1: busy=1 and slice k is on the ALU during cycle t+k.
- After edge t+WORDS: DONE, with done=1 and busy=0 for one cycle, and the outputs valid. Latency from start to done is WORDS+1 cycles.
- Back-to-back: start in the DONE cycle is accepted, so there is no IDLE gap. The minimum issue interval is WORDS+1 cycles.
- Reset asserted mid-RUN: abandon immediately, no done pulse, all outputs go to their reset values.
- The ALU path must settle within one clock period. The carry chain is registered between slices, so the critical path is the 16-bit ALU alone.

## Configuration
- ALU_SEQ_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in RUN forces IDLE at the next edge. There is no done pulse, and result, cout, ovf and zero keep their previous values.
  - abort is ignored outside RUN.
  - abort and start in the same cycle during RUN: abort wins and start is ignored.
- ALU_SEQ_ABORT_EN undefined: no abort port, and RUN always completes.

## Test plan
- WORDS=4, op=00, a=0x0000_0000_0000_FFFF, b=0x0000_0000_0000_0001, cin=0 → done exactly 5 cycles after start; result=0x0000_0000_0001_0000, cout=0, ovf=0, zero=0.
- op=00, a=0xFFFF_FFFF_FFFF_FFFF, b=0x0000_0000_0000_0000, cin=1 → result=0, cout=1, ovf=0, zero=1; alu_ci=1 on slices 1-3.
- op=00, a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → result=0x8000_0000_0000_0000, ovf=1, cout=0.
- op=01 with cin=1, a=b=0x1234_5678_9ABC_DEF0 → alu_ci=0 in every RUN cycle; result=0, zero=1, cout=0. A start pulse mid-RUN is ignored and done pulses once.
- Back-to-back: a second start in the DONE cycle → second done 5 cycles later. rst_n low at RUN cycle 2 → no done; all outputs 0 asynchronously.
- With ALU_SEQ_ABORT_EN: abort at RUN cycle 1 → IDLE next edge, no done, previous result retained.
